instr_loader: RTL and testbench

- Writer-side counterpart of the instruction memory: receives a program as a byte stream, assembles big-endian 32-bit instruction words, and drives the memory's word write port at consecutive byte addresses.
- Holds the CPU in reset while loading and signals completion.
- Sits between a host/boot byte source (UART RX, testbench) and the write port of the instruction memory.

---
 rtl/instr_loader.sv | 103 ++++++++++
 tb/tb_instr_loader.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// instr_loader: assembles a big-endian byte stream into 32-bit words for the instruction memory write port, holding the CPU in reset while loading.
// Optional INSTR_LOADER_CHECKSUM_EN: the final word is a 32-bit modular checksum of all written words and is verified, not written.
module instr_loader #(
  parameter int unsigned BASE_ADDR   = 40,
  parameter int unsigned DEPTH_WORDS = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [7:0]  word_count
);
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
  state_t      state_q;
  logic [1:0]  idx_q;
  logic        last_q;
  logic        err_q;
  logic [7:0]  cnt_q;
  logic [31:0] word_q;
  logic [31:0] addr_q;
  logic [31:0] word_d;
  logic        xfer;
  logic        ovf;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;
`endif
  assign byte_ready = state_q == LOAD;
  assign mem_we     = state_q == WRITE;
  assign cpu_hold   = state_q == LOAD || state_q == WRITE;
  assign done       = state_q == DONE;
  assign error      = err_q;
  assign word_count = cnt_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = word_q;
  assign xfer       = byte_valid & byte_ready;
  // First byte of a word clears the leftovers so short final words are zero padded.
  assign word_d     = (idx_q == 2'd0 ? 32'd0 : word_q) | ({byte_data, 24'd0} >> {idx_q, 3'd0});
  assign ovf        = (addr_q >> 2) >= 32'(DEPTH_WORDS);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
      word_q  <= 32'd0;
      addr_q  <= 32'(BASE_ADDR);
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum_q   <= 32'd0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q <= LOAD;
          addr_q  <= 32'(BASE_ADDR);
          cnt_q   <= 8'd0;
          idx_q   <= 2'd0;
          last_q  <= 1'b0;
          err_q   <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
          sum_q   <= 32'd0;
`endif
        end
        LOAD: if (xfer) begin
          word_q <= word_d;
          idx_q  <= idx_q + 2'd1;
          last_q <= byte_last;
          if (idx_q == 2'd3 || byte_last) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            if (byte_last) begin
              state_q <= DONE;
              err_q   <= idx_q != 2'd3 || word_d != sum_q;
            end else
`endif
            if (ovf) begin
              state_q <= DONE;
              err_q   <= 1'b1;
            end else state_q <= WRITE;
          end
        end
        WRITE: begin
          addr_q  <= addr_q + 32'd4;
          cnt_q   <= cnt_q + 8'd1;
          idx_q   <= 2'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
          sum_q   <= sum_q + word_q;
`endif
          state_q <= last_q ? DONE : LOAD;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: table-driven loads plus hand-written overflow, latency and mid-load reset sequences.
module tb_instr_loader;
  logic clk = 0, reset = 1, start = 0, byte_valid = 0, byte_last = 0;
  logic [7:0] byte_data = 0;
  logic rdy0, we0, hold0, done0, err0, rdy1, we1, hold1, done1, err1;
  logic [31:0] addr0, data0, addr1, data1;
  logic [7:0] cnt0, cnt1;
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam bit CK = 1;
`else
  localparam bit CK = 0;
`endif
  instr_loader u0 (.clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_last(byte_last), .byte_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(data0),
    .cpu_hold(hold0), .done(done0), .error(err0), .word_count(cnt0));
  instr_loader #(.BASE_ADDR(992), .DEPTH_WORDS(250)) u1 (.clk(clk), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last), .byte_ready(rdy1), .mem_we(we1),
    .mem_addr(addr1), .mem_wdata(data1), .cpu_hold(hold1), .done(done1), .error(err1), .word_count(cnt1));
  always #5 clk = ~clk;
  typedef struct {logic [31:0] a; logic [31:0] d; int c;} wr_t;
  typedef struct {int n; logic [95:0] b; int nw; logic [31:0] w0; logic [31:0] w1; logic err; logic [7:0] cnt;} vec_t;
  wr_t q0[$], q1[$];
  vec_t tbl[4];
  int cyc = 0, bad_ready = 0, tests = 0, fails = 0, acc_cyc = 0, nq;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (we0) q0.push_back(wr_t'{addr0, data0, cyc});
    if (we1) q1.push_back(wr_t'{addr1, data1, cyc});
    if (we0 && rdy0) bad_ready++;
  end
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic check_reset();
    check("rst_ready", rdy0, 0);
    check("rst_we", we0, 0);
    check("rst_addr", addr0, 40);
    check("rst_wdata", data0, 0);
    check("rst_hold", hold0, 0);
    check("rst_done", done0, 0);
    check("rst_error", err0, 0);
    check("rst_count", cnt0, 0);
  endtask
  task automatic do_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask
  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic send(bit sel, int n, logic [95:0] b, bit with_last);
    int t;
    for (int i = 0; i < n; i++) begin
      byte_valid = 1;
      byte_data = b[95-8*i -: 8];
      byte_last = with_last && i == n - 1;
      t = 0;
      while (!(sel ? rdy1 : rdy0) && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t == 20) begin
        check("accept_timeout", 0, 1);
        byte_valid = 0;
        byte_last = 0;
        return;
      end
      if (i == 0) acc_cyc = cyc;
      @(negedge clk);
    end
    byte_valid = 0;
    byte_last = 0;
  endtask
  task automatic wait_done(bit sel);
    int t;
    t = 0;
    while (!(sel ? done1 : done0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("done", sel ? done1 : done0, 1);
  endtask
  initial begin
`ifdef INSTR_LOADER_CHECKSUM_EN
    tbl[0] = '{12, 96'h00000001_00000002_00000003, 2, 32'h1, 32'h2, 0, 2};
    tbl[1] = '{12, 96'h00000001_00000002_00000004, 2, 32'h1, 32'h2, 1, 2};
    tbl[2] = '{3, {24'hAABBCC, 72'h0}, 0, 0, 0, 1, 0};
    tbl[3] = '{8, {64'h00000005_00000005, 32'h0}, 1, 32'h5, 0, 0, 1};
`else
    tbl[0] = '{8, {64'h20080002_20090002, 32'h0}, 2, 32'h20080002, 32'h20090002, 0, 2};
    tbl[1] = '{3, {24'hAABBCC, 72'h0}, 1, 32'hAABBCC00, 0, 0, 1};
    tbl[2] = '{5, {40'h11223344_55, 56'h0}, 2, 32'h11223344, 32'h55000000, 0, 2};
    tbl[3] = '{1, {8'h7F, 88'h0}, 1, 32'h7F000000, 0, 0, 1};
`endif
    repeat (2) @(negedge clk);
    reset = 0;
    check_reset();
    for (int i = 0; i < 4; i++) begin
      q0.delete();
      pulse_start();
      check("hold_loading", hold0, 1);
      send(0, tbl[i].n, tbl[i].b, 1);
      wait_done(0);
      check("error", err0, 32'(tbl[i].err));
      check("word_count", cnt0, 32'(tbl[i].cnt));
      check("hold_released", hold0, 0);
      check("num_writes", q0.size(), tbl[i].nw);
      if (q0.size() > 0 && tbl[i].nw > 0) begin
        check("w0_addr", q0[0].a, 40);
        check("w0_data", q0[0].d, tbl[i].w0);
      end
      if (q0.size() > 1 && tbl[i].nw > 1) begin
        check("w1_addr", q0[1].a, 44);
        check("w1_data", q0[1].d, tbl[i].w1);
      end
      if (i == 0 && q0.size() > 1) check("latency", q0[1].c - acc_cyc + 1, 10);
    end
    check("no_ready_in_write", bad_ready, 0);
    if (!CK) begin
      do_reset();
      q1.delete();
      pulse_start();
      send(1, 12, 96'h01020304_05060708_090A0B0C, 1);
      wait_done(1);
      check("ovf_writes", q1.size(), 2);
      if (q1.size() == 2) begin
        check("ovf_w0_addr", q1[0].a, 992);
        check("ovf_w0_data", q1[0].d, 32'h01020304);
        check("ovf_w1_addr", q1[1].a, 996);
        check("ovf_w1_data", q1[1].d, 32'h05060708);
      end
      check("ovf_error", err1, 1);
      check("ovf_count", cnt1, 2);
      check("ovf_addr_held", addr1, 1000);
    end
    do_reset();
    q0.delete();
    pulse_start();
    send(0, 6, 96'h11111111_2222_0000_0000_0000, 0);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check_reset();
    nq = q0.size();
    check("pre_reset_writes", nq, 1);
    repeat (5) @(negedge clk);
    check("no_we_after_reset", q0.size(), 1);
    check("idle_not_ready", rdy0, 0);
    pulse_start();
    send(0, 4, {32'hDEADBEEF, 64'h0}, 1);
    wait_done(0);
    check("reload_writes", q0.size(), CK ? 1 : 2);
    if (!CK && q0.size() == 2) begin
      check("reload_addr", q0[1].a, 40);
      check("reload_data", q0[1].d, 32'hDEADBEEF);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
